// File: rtl/tcb_sub_mem.sv
// TCB subordinate memory: byte-lane storage answering manager requests after a fixed DLY clocks.
// Each byte lane holds its own array; the response pipeline carries {rdt, err, wen}.
module tcb_sub_mem_lane #(
    parameter int SLW = 8,
    parameter int DEP = 1024,
    parameter int IW  = 10
)(
    input  logic           clk,
    input  logic           we,
    input  logic [IW-1:0]  idx,
    input  logic [SLW-1:0] wdt,
    output logic [SLW-1:0] rdt
);
    logic [SLW-1:0] mem [DEP];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdt;
    end

    assign rdt = mem[idx];
endmodule

module tcb_sub_mem #(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8,
    parameter int BEW = DBW/SLW,
    parameter int DLY = 1,
    parameter int SIZ = 4096
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    input  logic           rpt,
    input  logic           lck,
    input  logic           wen,
    input  logic [ABW-1:0] adr,
    input  logic [BEW-1:0] ben,
    input  logic [DBW-1:0] wdt,
    output logic [DBW-1:0] rdt,
    output logic           err,
    output logic           rdy
);
    localparam int AW = $clog2(SIZ);
    localparam int BW = $clog2(BEW);
    localparam int IW = AW - BW;

    typedef struct packed {
        logic [DBW-1:0] rdt;
        logic           err;
        logic           wen;
    } rsp_t;

    logic                    trn;
    logic                    rng;
    logic                    rsp;
    logic                    unused_lo;
    logic                    unused_ok;
    logic [IW-1:0]           idx;
    logic [BEW-1:0][SLW-1:0] wdt_l;
    logic [BEW-1:0][SLW-1:0] rdt_l;
    rsp_t                    s0;

    assign trn = vld & rdy;
    assign idx = adr[AW-1:BW];

    generate
        if (ABW > AW) begin : g_rng
            assign rng = |adr[ABW-1:AW];
        end else begin : g_no_rng
            assign rng = 1'b0;
        end
        if (BW > 0) begin : g_lo
            assign unused_lo = |adr[BW-1:0];
        end else begin : g_no_lo
            assign unused_lo = 1'b0;
        end
    endgenerate

    // A repeat read simply re-reads the array, which trivially returns the same word.
    assign unused_ok = &{1'b0, lck, rpt, rsp, unused_lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy <= 1'b0;
        else      rdy <= 1'b1;
    end

    assign wdt_l = wdt;

    for (genvar i = 0; i < BEW; i++) begin : g_lane
        tcb_sub_mem_lane #(
            .SLW (SLW),
            .DEP (SIZ/BEW),
            .IW  (IW)
        ) u_lane (
            .clk (clk),
            .we  (trn & wen & ben[i] & ~rng),
            .idx (idx),
            .wdt (wdt_l[i]),
            .rdt (rdt_l[i])
        );
    end

    always_comb begin
        s0.rdt = rng ? '0 : rdt_l;
        s0.err = rng;
        s0.wen = wen;
    end

    generate
        if (DLY == 0) begin : g_comb
            assign rdt = (trn && !wen) ? s0.rdt : '0;
            assign err = trn & s0.err;
            assign rsp = trn;
        end else begin : g_reg
            logic [DLY:1] vld_q;
            logic [DLY:0] vld_pipe;
            rsp_t         last;

            assign vld_pipe = {vld_q, trn};
            assign rsp      = vld_pipe[DLY];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) vld_q <= '0;
                else      vld_q <= vld_pipe[DLY-1:0];
            end

            if (DLY > 1) begin : g_mid
                rsp_t pipe [1:DLY-1];

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int k = 1; k < DLY; k++) pipe[k] <= '0;
                    end else begin
                        if (vld_pipe[0]) pipe[1] <= s0;
                        for (int k = 2; k < DLY; k++) begin
                            if (vld_pipe[k-1]) pipe[k] <= pipe[k-1];
                        end
                    end
                end

                assign last = pipe[DLY-1];
            end else begin : g_one
                assign last = s0;
            end

            // Write responses update err only; rdt keeps the last read data.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdt <= '0;
                    err <= 1'b0;
                end else if (vld_pipe[DLY-1]) begin
                    if (!last.wen) rdt <= last.rdt;
                    err <= last.err;
                end
            end
        end
    endgenerate
endmodule
